// File: rtl/seq_det_pkg.sv
// Shared constants for the sequence-detector chain: serializer width default
// and the shifter state encoding that the detector FSM package also uses.
package seq_det_pkg;

  localparam int SER_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/piso_serializer_hold_reg.sv
// One-entry holding register with a full flag. A write always wins over a
// simultaneous read, so a drain and a refill in one edge leave it full.
module hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_we,
  input  logic             out_re,
  output logic [WIDTH-1:0] out_data,
  output logic             out_full
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (in_we) begin
      data_d = in_data;
      full_d = 1'b1;
    end else if (out_re) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign out_data = data_q;
  assign out_full = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out front end for the sequence detector. A one-word
// holding register lets consecutive words leave with no gap bits.
module piso_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  shift_state_e     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;

  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             accept, free, hold_we, hold_re, active;

  assign load_ready = ~hold_full;
  assign accept     = load_valid & load_ready;
  assign active     = (state_q == ST_SHIFT);
  assign free       = ~active | (cnt_q == LAST_CNT);

  // Only the bypass case keeps an accepted word out of the holding register.
  assign hold_re = free & hold_full;
  assign hold_we = accept & ~(free & ~hold_full);

  hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .in_data  (load_data),
    .in_we    (hold_we),
    .out_re   (hold_re),
    .out_data (hold_data),
    .out_full (hold_full)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    if (free && hold_full) begin
      sr_d    = hold_data;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end else if (free && accept) begin
      sr_d    = load_data;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end else if (free) begin
      state_d = ST_IDLE;
    end else begin
      sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  assign ser_out     = active & (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
  assign ser_valid   = active;
  assign frame_start = active & (cnt_q == '0);
  assign frame_end   = active & (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a bit-queue model checks the 8-bit MSB-first
// instance every cycle; directed literals pin the 4-bit and LSB-first cases.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] ld8 = '0;
  logic       lv8 = 1'b0;
  logic       rdy8, so8, v8, fs8, fe8;
  logic [3:0] ld4 = '0;
  logic       lv4 = 1'b0;
  logic       rdy4, so4, v4, fs4, fe4;
  logic [7:0] ldl = '0;
  logic       lvl = 1'b0;
  logic       rdyl, sol, vl, fsl, fel;

  int checks = 0;
  int passes = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
    .clk(clk), .reset(reset), .load_data(ld8), .load_valid(lv8), .load_ready(rdy8),
    .ser_out(so8), .ser_valid(v8), .frame_start(fs8), .frame_end(fe8));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut4 (
    .clk(clk), .reset(reset), .load_data(ld4), .load_valid(lv4), .load_ready(rdy4),
    .ser_out(so4), .ser_valid(v4), .frame_start(fs4), .frame_end(fe4));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dutl (
    .clk(clk), .reset(reset), .load_data(ldl), .load_valid(lvl), .load_ready(rdyl),
    .ser_out(sol), .ser_valid(vl), .frame_start(fsl), .frame_end(fel));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Model: queue of bits still to appear on the wire, front = current bit.
  typedef struct packed {logic b; logic s; logic e;} mbit_t;
  mbit_t mq[$];
  logic  m_rdy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      m_rdy = (mq.size() <= 8);
      if (mq.size() > 0) void'(mq.pop_front());
      if (lv8 && m_rdy)
        for (int i = 0; i < 8; i++) mq.push_back('{ld8[7-i], (i == 0), (i == 7)});
    end
  end

  logic rec8[$];

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("ser_valid", {31'b0, v8}, {31'b0, (mq.size() > 0)});
      checkOutput("ser_out", {31'b0, so8}, {31'b0, (mq.size() > 0) ? mq[0].b : 1'b0});
      checkOutput("frame_start", {31'b0, fs8}, {31'b0, (mq.size() > 0) ? mq[0].s : 1'b0});
      checkOutput("frame_end", {31'b0, fe8}, {31'b0, (mq.size() > 0) ? mq[0].e : 1'b0});
      checkOutput("load_ready", {31'b0, rdy8}, {31'b0, (mq.size() <= 8)});
      if (v8) rec8.push_back(so8);
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
  task automatic applyStimulus(input logic [7:0] w);
    int guard = 0;
    ld8 = w;
    lv8 = 1'b1;
    while (!rdy8 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_timeout", {31'b0, (guard < 100)}, 32'd1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] recWord(input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n && i < rec8.size(); i++) r = {r[30:0], rec8[i]};
    return r;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  logic [3:0] pat4;
  logic [7:0] got4;
  int         valid4;
  int         found;

  initial begin
    #12;
    checkOutput("rst_ser_out", {31'b0, so8}, 32'd0);
    checkOutput("rst_ser_valid", {31'b0, v8}, 32'd0);
    checkOutput("rst_frame_start", {31'b0, fs8}, 32'd0);
    checkOutput("rst_frame_end", {31'b0, fe8}, 32'd0);
    checkOutput("rst_load_ready", {31'b0, rdy8}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // WIDTH=4 single word 1001
    pat4 = 4'b1001;
    ld4 = pat4;
    lv4 = 1'b1;
    @(negedge clk);
    lv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("w4_ser_out", {31'b0, so4}, {31'b0, pat4[3-i]});
      checkOutput("w4_frame_start", {31'b0, fs4}, {31'b0, (i == 0)});
      checkOutput("w4_frame_end", {31'b0, fe4}, {31'b0, (i == 3)});
      checkOutput("w4_valid", {31'b0, v4}, 32'd1);
      @(negedge clk);
    end
    checkOutput("w4_valid_falls", {31'b0, v4}, 32'd0);

    // WIDTH=4 boundary-spanning 1001 from 1100 then 1000
    ld4 = 4'b1100;
    lv4 = 1'b1;
    got4 = '0;
    valid4 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) ld4 = 4'b1000;
      if (i == 1) lv4 = 1'b0;
      got4 = {got4[6:0], so4};
      if (v4) valid4++;
    end
    checkOutput("w4_stream", {24'b0, got4}, 32'h000000C8);
    checkOutput("w4_gapfree", valid4, 32'd8);
    found = -1;
    for (int i = 0; i <= 4; i++)
      if (found < 0 && ((got4 >> (4 - i)) & 8'h0F) == 8'h09) found = i;
    checkOutput("w4_detect_1001_at", found, 32'd1);

    // LSB-first 8'h01
    ldl = 8'h01;
    lvl = 1'b1;
    @(negedge clk);
    lvl = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("lsb_ser_out", {31'b0, sol}, {31'b0, (i == 0)});
      checkOutput("lsb_valid", {31'b0, vl}, 32'd1);
      @(negedge clk);
    end

    // 8-bit streaming A5 then 3C with valid held high
    rec8.delete();
    applyStimulus(8'hA5);
    applyStimulus(8'h3C);
    checkOutput("ready_low_hold", {31'b0, rdy8}, 32'd0);
    lv8 = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("stream_len", rec8.size(), 32'd16);
    checkOutput("stream_bits", recWord(16), 32'h0000A53C);

    // valid toggling every cycle
    rec8.delete();
    applyStimulus(8'h12);
    lv8 = 1'b0;
    @(negedge clk);
    applyStimulus(8'h34);
    lv8 = 1'b0;
    @(negedge clk);
    applyStimulus(8'h56);
    lv8 = 1'b0;
    @(negedge clk);
    applyStimulus(8'h78);
    lv8 = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("toggle_len", rec8.size(), 32'd32);
    checkOutput("toggle_bits", recWord(32), 32'h12345678);

    // reset during third bit of FF with 0F held
    applyStimulus(8'hFF);
    applyStimulus(8'h0F);
    lv8 = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_ser_out", {31'b0, so8}, 32'd0);
    checkOutput("mid_rst_valid", {31'b0, v8}, 32'd0);
    checkOutput("mid_rst_fs", {31'b0, fs8}, 32'd0);
    checkOutput("mid_rst_fe", {31'b0, fe8}, 32'd0);
    checkOutput("mid_rst_ready", {31'b0, rdy8}, 32'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    rec8.delete();
    applyStimulus(8'h81);
    lv8 = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("post_rst_len", rec8.size(), 32'd8);
    checkOutput("post_rst_bits", recWord(8), 32'h00000081);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
